// File: rtl/prefetch_unit.sv
// rtl/prefetch_unit.sv - instruction prefetch queue feeding the decode register
// Optional drop counter output enabled by macro FETCH_PERF_EN.
module prefetch_unit #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  input  logic            FlushD,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
`ifdef FETCH_PERF_EN
  , output logic [31:0]   fetch_drop_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  slot_addr_q [DEPTH];
  logic [XLEN-1:0]  slot_data_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fill_ptr_q, fill_ptr_d;
  logic [CW-1:0]    count_q, count_d, unfilled_q, unfilled_d, discard_q, discard_d;
  logic [XLEN-1:0]  instr_q, instr_d, pcd_q, pcd_d, pcp4_q, pcp4_d;
  logic             validd_q, validd_d;

  logic [CW:0]      occ;
  logic             acc, fill, pop, head_ok;
  logic [CW-1:0]    outstanding;

  assign occ            = {1'b0, count_q} + {1'b0, discard_q};
  assign imem_req_valid = !rst && (occ < DEPTH_OCC) && !PCSrcE;
  assign imem_req_addr  = pc_q;
  assign acc            = imem_req_valid && imem_req_ready;
  assign fill           = imem_rsp_valid && (discard_q == '0) && !PCSrcE && (unfilled_q != '0);
  assign head_ok        = (count_q != '0) && filled_q[head_q];
  assign pop            = head_ok && (!validd_q || !StallD) && !PCSrcE && !FlushD;
  assign outstanding    = discard_q + unfilled_q;

  always_comb begin
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_ptr_d = fill_ptr_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;
    discard_d  = discard_q;
    filled_d   = filled_q;
    if (PCSrcE) begin
      // Every in-flight request becomes a response to discard, except one landing now.
      pc_d       = PCTargetE & WORD_MASK;
      head_d     = '0;
      tail_d     = '0;
      fill_ptr_d = '0;
      count_d    = '0;
      unfilled_d = '0;
      filled_d   = '0;
      discard_d  = (imem_rsp_valid && outstanding != '0) ? outstanding - CW'(1) : outstanding;
    end else begin
      if (acc) begin
        pc_d             = pc_q + XLEN'(4);
        filled_d[tail_q] = 1'b0;
      end
      if (fill) filled_d[fill_ptr_q] = 1'b1;
      if (imem_rsp_valid && discard_q != '0) discard_d = discard_q - CW'(1);
      tail_d     = tail_q + PW'(acc);
      fill_ptr_d = fill_ptr_q + PW'(fill);
      head_d     = head_q + PW'(pop);
      count_d    = count_q + CW'(acc) - CW'(pop);
      unfilled_d = unfilled_q + CW'(acc) - CW'(fill);
    end
  end

  always_comb begin
    validd_d = validd_q;
    instr_d  = instr_q;
    pcd_d    = pcd_q;
    pcp4_d   = pcp4_q;
    if (PCSrcE || FlushD) begin
      validd_d = 1'b0;
    end else if (pop) begin
      validd_d = 1'b1;
      instr_d  = slot_data_q[head_q];
      pcd_d    = slot_addr_q[head_q];
      pcp4_d   = slot_addr_q[head_q] + XLEN'(4);
    end else if (!StallD) begin
      validd_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC & WORD_MASK;
      head_q     <= '0;
      tail_q     <= '0;
      fill_ptr_q <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      discard_q  <= '0;
      filled_q   <= '0;
      validd_q   <= 1'b0;
      instr_q    <= '0;
      pcd_q      <= '0;
      pcp4_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_ptr_q <= fill_ptr_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
      discard_q  <= discard_d;
      filled_q   <= filled_d;
      validd_q   <= validd_d;
      instr_q    <= instr_d;
      pcd_q      <= pcd_d;
      pcp4_q     <= pcp4_d;
    end
  end

  // Slot payload needs no reset: the filled flags and count gate every read.
  always_ff @(posedge clk) begin
    if (acc)  slot_addr_q[tail_q]     <= pc_q;
    if (fill) slot_data_q[fill_ptr_q] <= imem_rsp_data;
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = validd_q;

`ifdef FETCH_PERF_EN
  logic [31:0] drop_cnt_q;
  logic        dropped;

  assign dropped = imem_rsp_valid && (PCSrcE || discard_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (dropped && drop_cnt_q != 32'hFFFF_FFFF) begin
      drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign fetch_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// tb/tb_prefetch_unit.sv - directed self-checking bench for prefetch_unit
module tb_prefetch_unit;

  localparam logic [31:0] K = 32'h1357_9BDF;

  logic clk, rst;
  logic pcsrc, stall, flush;
  logic [31:0] target;

  logic req_valid, req_ready, rsp_valid;
  logic [31:0] req_addr, rsp_data, instr, pcd, pcp4;
  logic validd;

  logic b_req_valid, b_rsp_valid;
  logic [31:0] b_req_addr, b_rsp_data, b_instr, b_pcd, b_pcp4;
  logic b_validd;

`ifdef FETCH_PERF_EN
  logic [31:0] drop_cnt, b_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  bit found;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend_q[$];

  logic        acc_s, b_acc_s;
  logic [31:0] addr_s, b_addr_s;

  prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) u0 (
    .clk(clk), .rst(rst), .PCSrcE(pcsrc), .PCTargetE(target),
    .StallD(stall), .FlushD(flush),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .InstrD(instr), .PCD(pcd), .PCPlus4D(pcp4), .ValidD(validd)
`ifdef FETCH_PERF_EN
    , .fetch_drop_cnt(drop_cnt)
`endif
  );

  prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u1 (
    .clk(clk), .rst(rst), .PCSrcE(1'b0), .PCTargetE(32'h0),
    .StallD(1'b0), .FlushD(1'b0),
    .imem_req_valid(b_req_valid), .imem_req_ready(1'b1), .imem_req_addr(b_req_addr),
    .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
    .InstrD(b_instr), .PCD(b_pcd), .PCPlus4D(b_pcp4), .ValidD(b_validd)
`ifdef FETCH_PERF_EN
    , .fetch_drop_cnt(b_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshakes are sampled mid-cycle, when every input is settled for the coming edge.
  always @(negedge clk) begin
    acc_s    = req_valid && req_ready;
    addr_s   = req_addr;
    b_acc_s  = b_req_valid;
    b_addr_s = b_req_addr;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && acc_s) pend_q.push_back('{addr: addr_s, due: cyc + lat - 1});
    #1;
    if (rst) begin
      pend_q.delete();
      rsp_valid   = 1'b0;
      b_rsp_valid = 1'b0;
    end else begin
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        rsp_valid = 1'b1;
        rsp_data  = pend_q[0].addr ^ K;
        void'(pend_q.pop_front());
      end else begin
        rsp_valid = 1'b0;
      end
      b_rsp_valid = b_acc_s;
      b_rsp_data  = b_addr_s ^ K;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pcsrc = 1'b0; stall = 1'b0; flush = 1'b0; target = '0;
    req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    b_rsp_valid = 1'b0; b_rsp_data = '0;
    step(); step();
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_validd", {31'b0, validd}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pcd", pcd, 32'h0);
    chk("rst_pcp4", pcp4, 32'h0);
    chk("rst_b_req_valid", {31'b0, b_req_valid}, 32'd0);

    rst = 1'b0;
    #1;
    chk("rel_req_valid", {31'b0, req_valid}, 32'd1);
    chk("rel_addr0", req_addr, 32'h0);
    chk("wrap_addr0", b_req_addr, 32'hFFFF_FFF8);

    step();
    chk("addr1", req_addr, 32'h4);
    chk("e1_validd", {31'b0, validd}, 32'd0);
    chk("wrap_addr1", b_req_addr, 32'hFFFF_FFFC);
    step();
    chk("addr2", req_addr, 32'h8);
    chk("e2_validd", {31'b0, validd}, 32'd0);
    chk("wrap_addr2", b_req_addr, 32'h0);
    step();
    chk("first_validd", {31'b0, validd}, 32'd1);
    chk("first_pcd", pcd, 32'h0);
    chk("first_pcp4", pcp4, 32'h4);
    chk("first_instr", instr, K);
    step();
    chk("second_pcd", pcd, 32'h4);
    chk("wrap_pcd", b_pcd, 32'hFFFF_FFFC);
    chk("wrap_pcp4", b_pcp4, 32'h0);

    stall = 1'b1;
    step();
    chk("stall1_pcd", pcd, 32'h4);
    step();
    chk("stall2_pcd", pcd, 32'h4);
    chk("full_req_valid", {31'b0, req_valid}, 32'd0);
    step();
    chk("stall3_pcd", pcd, 32'h4);
    chk("stall3_instr", instr, 32'h4 ^ K);
    chk("full2_req_valid", {31'b0, req_valid}, 32'd0);
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("resume_validd", {31'b0, validd}, 32'd1);
      chk("resume_pcd", pcd, 32'h8 + 32'(4 * i));
    end

    flush = 1'b1; stall = 1'b1;
    step();
    chk("flush_validd", {31'b0, validd}, 32'd0);
    flush = 1'b0; stall = 1'b0;
    step();
    chk("post_flush_validd", {31'b0, validd}, 32'd1);
    chk("post_flush_pcd", pcd, 32'h1C);

    req_ready = 1'b0;
    step(); step(); step();
    chk("drain_pcd", pcd, 32'h28);
    req_ready = 1'b1;
    lat = 3;
    step(); step();
    pcsrc = 1'b1; target = 32'h0000_0013;
    #1;
    chk("redir_req_valid", {31'b0, req_valid}, 32'd0);
    step();
    pcsrc = 1'b0;
    #1;
    chk("redir_validd", {31'b0, validd}, 32'd0);
    chk("redir_addr", req_addr, 32'h10);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (validd) found = 1'b1;
    end
    chk("redir_found", {31'b0, found}, 32'd1);
    chk("redir_pcd", pcd, 32'h10);
    chk("redir_instr", instr, 32'h10 ^ K);
`ifdef FETCH_PERF_EN
    chk("drop_cnt", drop_cnt, 32'd2);
`endif

    step();
    #1;
    rst = 1'b1;
    #1;
    chk("async_validd", {31'b0, validd}, 32'd0);
    chk("async_req_valid", {31'b0, req_valid}, 32'd0);
    chk("async_pcd", pcd, 32'h0);
    step(); step();
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
